// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: packet-locked ARP/ping/UDP arbiter feeding the TX FIFO.
// Define TX_ARB_IPG_EN to insert IPG_WORDS idle cycles after every EOP.
module eth_tx_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 1024,
  parameter int IPG_WORDS    = 3,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   i_arp_data,
  input  logic          i_arp_vld,
  input  logic          i_arp_sop,
  input  logic          i_arp_eop,
  output logic          o_arp_rdy,
  input  logic [31:0]   i_ping_data,
  input  logic          i_ping_vld,
  input  logic          i_ping_sop,
  input  logic          i_ping_eop,
  output logic          o_ping_rdy,
  input  logic [31:0]   i_udp_data,
  input  logic          i_udp_vld,
  input  logic          i_udp_sop,
  input  logic          i_udp_eop,
  output logic          o_udp_rdy,
  output logic [31:0]   o_tx_data,
  output logic          o_tx_vld,
  output logic          o_tx_sop,
  output logic          o_tx_eop,
  input  logic          i_tx_rdy,
  output logic [1:0]    o_grant,
  output logic          o_busy,
  output logic [CW-1:0] o_pkt_cnt,
  output logic [CW-1:0] o_err_cnt,
  input  logic          i_clr_cnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

`ifdef TX_ARB_IPG_EN
  localparam int GW = $clog2(IPG_WORDS + 1);
  typedef enum logic [1:0] {IDLE, LOCK, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOCK} state_t;
`endif

  state_t        state;
  logic [1:0]    grant;
  logic          busy;
  logic [SW-1:0] starve;
  logic [IW-1:0] idle;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] err_cnt;
`ifdef TX_ARB_IPG_EN
  logic [GW-1:0] gap_cnt;
`endif

  logic        arp_req;
  logic        ping_req;
  logic        udp_req;
  logic        arb_en;
  logic [1:0]  win;
  logic [31:0] sel_data;
  logic        sel_vld;
  logic        sel_sop;
  logic        sel_eop;
  logic        locked;
  logic        eop_xfer;
  logic        timeout_hit;
  logic        starved;

  assign arp_req  = i_arp_vld & i_arp_sop;
  assign ping_req = i_ping_vld & i_ping_sop;
  assign udp_req  = i_udp_vld & i_udp_sop;
  assign starved  = starve == SW'(STARVE_LIMIT);

`ifdef TX_ARB_IPG_EN
  // The last gap cycle doubles as the arbitration cycle.
  assign arb_en = (state == IDLE) |
                  ((state == GAP) &
                   (gap_cnt == GW'(IPG_WORDS - 1)));
`else
  assign arb_en = state == IDLE;
`endif

  always_comb begin
    win = 2'd0;
    if (udp_req & starved)
      win = 2'd3;
    else if (arp_req)
      win = 2'd1;
    else if (ping_req)
      win = 2'd2;
    else if (udp_req)
      win = 2'd3;
  end

  always_comb begin
    sel_data = 32'h0;
    sel_vld  = 1'b0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    unique case (grant)
      2'd1: begin
        sel_data = i_arp_data;
        sel_vld  = i_arp_vld;
        sel_sop  = i_arp_sop;
        sel_eop  = i_arp_eop;
      end
      2'd2: begin
        sel_data = i_ping_data;
        sel_vld  = i_ping_vld;
        sel_sop  = i_ping_sop;
        sel_eop  = i_ping_eop;
      end
      2'd3: begin
        sel_data = i_udp_data;
        sel_vld  = i_udp_vld;
        sel_sop  = i_udp_sop;
        sel_eop  = i_udp_eop;
      end
      default: ;
    endcase
  end

  assign locked      = state == LOCK;
  assign eop_xfer    = locked & sel_vld &
                       i_tx_rdy & sel_eop;
  assign timeout_hit = locked & ~sel_vld &
                       (idle == IW'(TIMEOUT - 1));

  // grant is zero outside LOCK, so the data path
  // falls silent as soon as the lock is dropped.
  assign o_tx_data  = sel_data;
  assign o_tx_vld   = sel_vld;
  assign o_tx_sop   = sel_sop;
  assign o_tx_eop   = sel_eop;
  assign o_arp_rdy  = (grant == 2'd1) & i_tx_rdy;
  assign o_ping_rdy = (grant == 2'd2) & i_tx_rdy;
  assign o_udp_rdy  = (grant == 2'd3) & i_tx_rdy;
  assign o_grant    = grant;
  assign o_busy     = busy;
  assign o_pkt_cnt  = pkt_cnt;
  assign o_err_cnt  = err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= 2'd0;
      busy    <= 1'b0;
      starve  <= '0;
      idle    <= '0;
      pkt_cnt <= '0;
      err_cnt <= '0;
`ifdef TX_ARB_IPG_EN
      gap_cnt <= '0;
`endif
    end else begin
      if (!udp_req)
        starve <= '0;
      else if (arb_en && win == 2'd3)
        starve <= '0;
      else if (arb_en && win != 2'd0 && !starved)
        starve <= starve + 1'b1;

      if (i_clr_cnt)
        pkt_cnt <= '0;
      else if (eop_xfer)
        pkt_cnt <= pkt_cnt + 1'b1;

      if (i_clr_cnt)
        err_cnt <= '0;
      else if (timeout_hit && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (win != 2'd0) begin
            state <= LOCK;
            grant <= win;
            busy  <= 1'b1;
            idle  <= '0;
          end
        end
        LOCK: begin
          if (eop_xfer) begin
            grant <= 2'd0;
            busy  <= 1'b0;
            idle  <= '0;
`ifdef TX_ARB_IPG_EN
            state   <= GAP;
            gap_cnt <= '0;
`else
            state <= IDLE;
`endif
          end else if (timeout_hit) begin
            state <= IDLE;
            grant <= 2'd0;
            busy  <= 1'b0;
            idle  <= '0;
          end else if (!sel_vld) begin
            idle <= idle + 1'b1;
          end else begin
            idle <= '0;
          end
        end
`ifdef TX_ARB_IPG_EN
        GAP: begin
          if (arb_en) begin
            gap_cnt <= '0;
            if (win != 2'd0) begin
              state <= LOCK;
              grant <= win;
              busy  <= 1'b1;
              idle  <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed packet scenarios with a per-cycle
// reference model of the arbitration rules.
module tb_eth_tx_arbiter;

  localparam int LIMIT = 4;
  localparam int TMO   = 1024;
`ifdef TX_ARB_IPG_EN
  localparam int GAPX = 3;
`else
  localparam int GAPX = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:1]  vld = '0;
  logic [3:1]  sop = '0;
  logic [3:1]  eop = '0;
  logic [31:0] dat [1:3];
  logic        tx_rdy = 1'b1;
  logic        clr = 1'b0;

  logic [31:0] o_tx_data;
  logic        o_tx_vld, o_tx_sop, o_tx_eop;
  logic        arp_rdy, ping_rdy, udp_rdy;
  logic [1:0]  o_grant;
  logic        o_busy;
  logic [15:0] o_pkt_cnt, o_err_cnt;
  logic [3:1]  rdy;
  assign rdy = {udp_rdy, ping_rdy, arp_rdy};

  eth_tx_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_arp_data(dat[1]), .i_arp_vld(vld[1]),
    .i_arp_sop(sop[1]), .i_arp_eop(eop[1]),
    .o_arp_rdy(arp_rdy),
    .i_ping_data(dat[2]), .i_ping_vld(vld[2]),
    .i_ping_sop(sop[2]), .i_ping_eop(eop[2]),
    .o_ping_rdy(ping_rdy),
    .i_udp_data(dat[3]), .i_udp_vld(vld[3]),
    .i_udp_sop(sop[3]), .i_udp_eop(eop[3]),
    .o_udp_rdy(udp_rdy),
    .o_tx_data(o_tx_data), .o_tx_vld(o_tx_vld),
    .o_tx_sop(o_tx_sop), .o_tx_eop(o_tx_eop),
    .i_tx_rdy(tx_rdy), .o_grant(o_grant),
    .o_busy(o_busy), .o_pkt_cnt(o_pkt_cnt),
    .o_err_cnt(o_err_cnt), .i_clr_cnt(clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Packet sources: each has a batch count, a length, and an optional stall.
  int npk [1:3];
  int plen [1:3];
  int act [1:3];
  int w [1:3];
  int sq [1:3];
  int stall_at [1:3];
  int stall_len [1:3];
  int stall_cnt [1:3];
  logic [3:1] fire = '0;
  bit toggle = 0;
  bit man_clr = 0;
  int clr_src = 0;

  initial begin
    for (int k = 1; k <= 3; k++) begin
      npk[k] = 0; plen[k] = 0; act[k] = 0;
      w[k] = 0; sq[k] = 0; stall_at[k] = -1;
      stall_len[k] = 0; stall_cnt[k] = 0;
      dat[k] = '0;
    end
  end

  always @(negedge clk) fire = vld & rdy;

  always @(posedge clk) begin
    #1;
    for (int k = 1; k <= 3; k++) begin
      if (fire[k] && act[k] != 0) begin
        w[k]++;
        if (w[k] == stall_at[k]) begin
          stall_cnt[k] = stall_len[k];
          stall_at[k] = -1;
        end
        if (w[k] == act[k]) begin
          act[k] = 0;
          sq[k]++;
        end
      end
      if (act[k] == 0 && npk[k] > 0) begin
        npk[k]--;
        act[k] = plen[k];
        w[k] = 0;
      end
      vld[k] = act[k] != 0 && stall_cnt[k] == 0;
      sop[k] = vld[k] && w[k] == 0;
      eop[k] = vld[k] && w[k] == act[k] - 1;
      dat[k] = vld[k] ?
        {8'(k), sq[k][7:0], w[k][15:0]} : 32'h0;
      if (stall_cnt[k] > 0) stall_cnt[k]--;
    end
    tx_rdy = toggle ? ~tx_rdy : 1'b1;
    clr = man_clr;
    if (clr_src != 0 && o_grant == 2'(clr_src) &&
        vld[clr_src] && eop[clr_src] && tx_rdy)
      clr = 1'b1;
  end

  function automatic bit pending();
    return (npk[1] + npk[2] + npk[3] +
            act[1] + act[2] + act[3]) != 0;
  endfunction

  // Reference model: owner 0 means no lock; wt counts blank
  // cycles still owed after an EOP before arbitration resumes.
  int m_own = 0, m_wait = 0, m_idle = 0;
  int m_starve = 0, m_pkt = 0, m_err = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int own, wt, idl, stv, pk, er, win;
    logic [3:1] rq;
    if (!rst_n) begin
      m_own <= 0; m_wait <= 0; m_idle <= 0;
      m_starve <= 0; m_pkt <= 0; m_err <= 0;
    end else begin
      own = m_own; wt = m_wait; idl = m_idle;
      stv = m_starve; pk = m_pkt; er = m_err;
      win = 0;
      rq = vld & sop;
      if (m_own == 0) begin
        if (m_wait > 0) wt = m_wait - 1;
        else begin
          if (rq[3] && m_starve == LIMIT) win = 3;
          else if (rq[1]) win = 1;
          else if (rq[2]) win = 2;
          else if (rq[3]) win = 3;
          own = win;
          idl = 0;
        end
      end else if (vld[m_own] && tx_rdy && eop[m_own]) begin
        own = 0; pk = pk + 1; wt = GAPX - 1; idl = 0;
      end else if (!vld[m_own]) begin
        idl = idl + 1;
        if (idl == TMO) begin
          own = 0; idl = 0;
          if (er < 65535) er = er + 1;
        end
      end else begin
        idl = 0;
      end
      if (!rq[3]) stv = 0;
      else if (win == 3) stv = 0;
      else if (win != 0 && stv < LIMIT) stv = stv + 1;
      if (clr) begin pk = 0; er = 0; end
      m_own <= own; m_wait <= wt; m_idle <= idl;
      m_starve <= stv; m_pkt <= pk % 65536; m_err <= er;
    end
  end

  always @(negedge clk) begin : compare
    logic [3:1] er_rdy;
    er_rdy = '0;
    if (m_own != 0) er_rdy[m_own] = tx_rdy;
    chk("grant", 32'(o_grant), 32'(m_own));
    chk("busy", 32'(o_busy), 32'(m_own != 0));
    chk("tx_vld", 32'(o_tx_vld),
        32'(m_own != 0 && vld[m_own]));
    chk("tx_sop", 32'(o_tx_sop),
        32'(m_own != 0 && sop[m_own]));
    chk("tx_eop", 32'(o_tx_eop),
        32'(m_own != 0 && eop[m_own]));
    chk("tx_data", o_tx_data,
        m_own != 0 ? dat[m_own] : 32'h0);
    chk("rdy", 32'(rdy), 32'(er_rdy));
    chk("pkt_cnt", 32'(o_pkt_cnt), 32'(m_pkt));
    chk("err_cnt", 32'(o_err_cnt), 32'(m_err));
  end

  // Logs of accepted words and grant changes.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [31:0] tx_d [$];
  bit tx_s [$];
  bit tx_e [$];
  int tx_c [$];
  int gnz [$];
  int gnz_c [$];
  int gz_c [$];
  logic [1:0] g_prev = 2'd0;

  always @(negedge clk) begin
    if (o_tx_vld && tx_rdy) begin
      tx_d.push_back(o_tx_data);
      tx_s.push_back(o_tx_sop);
      tx_e.push_back(o_tx_eop);
      tx_c.push_back(cyc);
    end
    if (o_grant != g_prev) begin
      if (o_grant != 2'd0) begin
        gnz.push_back(int'(o_grant));
        gnz_c.push_back(cyc);
      end else begin
        gz_c.push_back(cyc);
      end
      g_prev = o_grant;
    end
  end

  task automatic clear_logs();
    tx_d.delete(); tx_s.delete(); tx_e.delete();
    tx_c.delete(); gnz.delete(); gnz_c.delete();
    gz_c.delete();
  endtask

  task automatic wait_done(input string nm);
    int c = 0;
    while (c < 400 && (pending() || o_busy)) begin
      @(posedge clk);
      c++;
    end
    n_cmp++;
    if (c >= 400) begin
      n_bad++;
      $display("FAIL %s: no completion in 400 cycles", nm);
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic chk_grants(input string nm,
                            input int exp [$]);
    chk({nm, "_n"}, 32'(gnz.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < gnz.size(); i++)
      chk(nm, 32'(gnz[i]), 32'(exp[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int wc;
    int wcyc;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_vld", 32'(o_tx_vld), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_pkt", 32'(o_pkt_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);

    // All three request together: ARP, ping, UDP.
    clear_logs();
    plen[1] = 3; plen[2] = 2; plen[3] = 4;
    npk[1] = 1; npk[2] = 1; npk[3] = 1;
    wait_done("prio");
    chk_grants("prio_order", '{1, 2, 3});
    chk("prio_pkt", 32'(o_pkt_cnt), 32'd3);

    // Backpressure on a 16-word UDP packet.
    clear_logs();
    toggle = 1;
    plen[3] = 16; npk[3] = 1;
    wait_done("bp");
    toggle = 0;
    chk("bp_words", 32'(tx_d.size()), 32'd16);
    for (int i = 0; i < tx_d.size(); i++) begin
      chk("bp_idx", 32'(tx_d[i][15:0]), 32'(i));
      chk("bp_sop", 32'(tx_s[i]), 32'(i == 0));
      chk("bp_eop", 32'(tx_e[i]), 32'(i == 15));
    end
    chk("bp_pkt", 32'(o_pkt_cnt), 32'd4);

    // UDP waits behind a stream of control packets.
    clear_logs();
    plen[1] = 2; plen[2] = 2; plen[3] = 3;
    npk[1] = 5; npk[2] = 5; npk[3] = 1;
    wait_done("starve");
    chk_grants("starve_order",
               '{1, 1, 1, 1, 3, 1, 2, 2, 2, 2, 2});
    chk("starve_pkt", 32'(o_pkt_cnt), 32'd15);

    // Two back-to-back UDP packets: blank cycles between them.
    clear_logs();
    plen[3] = 4; npk[3] = 2;
    wait_done("gap");
    chk("gap_words", 32'(tx_d.size()), 32'd8);
    if (tx_c.size() == 8) begin
      chk("gap_eop", 32'(tx_e[3]), 32'd1);
      chk("gap_sop", 32'(tx_s[4]), 32'd1);
      chk("gap_len", 32'(tx_c[4] - tx_c[3] - 1),
          32'(GAPX));
    end

    // Ping stalls after 2 words; UDP waits for the abort.
    clear_logs();
    plen[2] = 6; stall_at[2] = 2; stall_len[2] = 3000;
    plen[3] = 2;
    npk[2] = 1; npk[3] = 1;
    repeat (1100) @(posedge clk);
    chk("tmo_err", 32'(o_err_cnt), 32'd1);
    chk_grants("tmo_order", '{2, 3});
    chk("tmo_words", 32'(tx_d.size()), 32'd4);
    if (tx_d.size() >= 2 && gnz_c.size() == 2 &&
        gz_c.size() >= 1) begin
      wcyc = tx_c[1];
      chk("tmo_src", 32'(tx_d[1][31:24]), 32'd2);
      chk("tmo_drop", 32'(gz_c[0] - wcyc), 32'd1025);
      chk("tmo_regrant", 32'(gnz_c[1] - wcyc), 32'd1026);
    end
    act[2] = 0; stall_cnt[2] = 0;
    wait_done("tmo");
    chk("tmo_pkt", 32'(o_pkt_cnt), 32'd18);

    // Single-word packet whose EOP coincides with clear.
    clear_logs();
    clr_src = 1;
    plen[1] = 1; npk[1] = 1;
    wait_done("clr");
    clr_src = 0;
    chk("clr_pkt", 32'(o_pkt_cnt), 32'd0);
    chk("clr_err", 32'(o_err_cnt), 32'd0);
    npk[1] = 1;
    wait_done("one");
    chk("one_words", 32'(tx_d.size()), 32'd2);
    chk("one_pkt", 32'(o_pkt_cnt), 32'd1);

    // Reset in the middle of an ARP packet.
    plen[1] = 10; npk[1] = 1;
    wc = 0;
    do begin
      @(negedge clk);
      wc++;
    end while (wc < 100 && !(act[1] != 0 && w[1] == 5));
    chk("rstm_reach", 32'(w[1]), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_grant", 32'(o_grant), 32'd0);
    chk("rstm_vld", 32'(o_tx_vld), 32'd0);
    chk("rstm_data", o_tx_data, 32'h0);
    chk("rstm_rdy", 32'(arp_rdy), 32'd0);
    chk("rstm_pkt", 32'(o_pkt_cnt), 32'd0);
    act[1] = 0; npk[1] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    clear_logs();
    plen[1] = 3; npk[1] = 1;
    wait_done("rstm_fresh");
    chk_grants("rstm_order", '{1});
    chk("rstm_words", 32'(tx_d.size()), 32'd3);
    chk("rstm_pkt2", 32'(o_pkt_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
